// File: rtl/ff_en_exerciser.sv
// rtl/ff_en_exerciser.sv - LFSR stimulus generator and response checker for the ff_en register
module ff_en_exerciser #(
  parameter int unsigned WIDTH   = 10,
  parameter int unsigned NUM_VEC = 64,
  parameter logic [15:0] SEED    = 16'h8155
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] d_out,
  output logic [WIDTH-1:0] d_in,
  output logic             d_en,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic [15:0]      first_err_idx,
  output logic [WIDTH-1:0] first_err_exp,
  output logic [WIDTH-1:0] first_err_got
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [15:0] LAST_IDX = 16'(NUM_VEC - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [15:0]      vec_cnt_q, vec_cnt_d;
  logic [15:0]      chk_idx_q, chk_idx_d;
  logic             chk_v_q, chk_v_d;
  logic [WIDTH-1:0] d_in_q, d_in_d;
  logic             d_en_q, d_en_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             pass_q, pass_d;
  logic [7:0]       err_count_q, err_count_d;
  logic [15:0]      first_err_idx_q, first_err_idx_d;
  logic [WIDTH-1:0] first_err_exp_q, first_err_exp_d;
  logic [WIDTH-1:0] first_err_got_q, first_err_got_d;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  always_comb begin
    state_d         = state_q;
    lfsr_d          = lfsr_q;
    vec_cnt_d       = vec_cnt_q;
    d_in_d          = d_in_q;
    d_en_d          = d_en_q;
    pass_d          = pass_q;
    err_count_d     = err_count_q;
    first_err_idx_d = first_err_idx_q;
    first_err_exp_d = first_err_exp_q;
    first_err_got_d = first_err_got_q;

    // exp_q tracks what ff_en holds; the vector presented last cycle is checked now
    exp_d     = d_en_q ? d_in_q : exp_q;
    chk_v_d   = (state_q == S_RUN);
    chk_idx_d = vec_cnt_q;

    if (chk_v_q && (d_out != exp_q)) begin
      if (err_count_q == 8'd0) begin
        first_err_idx_d = chk_idx_q;
        first_err_exp_d = exp_q;
        first_err_got_d = d_out;
      end
      if (err_count_q != 8'hFF) begin
        err_count_d = err_count_q + 8'd1;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        d_in_d = '0;
        d_en_d = 1'b0;
        if (start) begin
          state_d         = S_RUN;
          d_in_d          = SEED_EFF[WIDTH-1:0];
          d_en_d          = 1'b1;
          lfsr_d          = lfsr_next(SEED_EFF);
          vec_cnt_d       = 16'd0;
          pass_d          = 1'b0;
          err_count_d     = 8'd0;
          first_err_idx_d = 16'd0;
          first_err_exp_d = '0;
          first_err_got_d = '0;
        end
      end
      S_RUN: begin
        if (vec_cnt_q == LAST_IDX) begin
          state_d = S_DRAIN;
          d_in_d  = '0;
          d_en_d  = 1'b0;
        end else begin
          d_in_d    = lfsr_q[WIDTH-1:0];
          d_en_d    = lfsr_q[15];
          lfsr_d    = lfsr_next(lfsr_q);
          vec_cnt_d = vec_cnt_q + 16'd1;
        end
      end
      S_DRAIN: begin
        // the final vector's check lands on this edge, so judge on the updated count
        state_d = S_DONE;
        d_in_d  = '0;
        d_en_d  = 1'b0;
        pass_d  = (err_count_d == 8'd0);
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      lfsr_q          <= SEED_EFF;
      vec_cnt_q       <= 16'd0;
      chk_idx_q       <= 16'd0;
      chk_v_q         <= 1'b0;
      d_in_q          <= '0;
      d_en_q          <= 1'b0;
      exp_q           <= '0;
      pass_q          <= 1'b0;
      err_count_q     <= 8'd0;
      first_err_idx_q <= 16'd0;
      first_err_exp_q <= '0;
      first_err_got_q <= '0;
    end else begin
      state_q         <= state_d;
      lfsr_q          <= lfsr_d;
      vec_cnt_q       <= vec_cnt_d;
      chk_idx_q       <= chk_idx_d;
      chk_v_q         <= chk_v_d;
      d_in_q          <= d_in_d;
      d_en_q          <= d_en_d;
      exp_q           <= exp_d;
      pass_q          <= pass_d;
      err_count_q     <= err_count_d;
      first_err_idx_q <= first_err_idx_d;
      first_err_exp_q <= first_err_exp_d;
      first_err_got_q <= first_err_got_d;
    end
  end

  assign d_in          = d_in_q;
  assign d_en          = d_en_q;
  assign busy          = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done          = (state_q == S_DONE);
  assign pass          = pass_q;
  assign err_count     = err_count_q;
  assign first_err_idx = first_err_idx_q;
  assign first_err_exp = first_err_exp_q;
  assign first_err_got = first_err_got_q;

endmodule
